// File: rtl/ushift_burst_if.sv
// Control and data bundle for ushift_burst; the master drives commands and the slave returns register state.
interface ushift_burst_if #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
);
  logic          load;
  logic [N-1:0]  d;
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] amount;
  logic          lin;
  logic          rin;
  logic [N-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;

  modport master (
    output load, d, start, mode, amount, lin, rin,
    input  q, sout, busy, done
  );

  modport slave (
    input  load, d, start, mode, amount, lin, rin,
    output q, sout, busy, done
  );
endinterface

// File: rtl/ushift_burst.sv
// N-bit universal shift register; one start runs `amount` single-bit steps, giving a final q and a done pulse amount cycles later.
// Commands are dropped while busy (no stall); USHIFT_ARITH_EN turns mode 01 into an arithmetic right shift.
module ushift_burst #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  ushift_burst_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [1:0]    mode_r;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mode_r   <= 2'b00;
      count    <= '0;
      bus.q    <= '0;
      bus.sout <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            bus.q <= bus.d;
          end else if (bus.start) begin
            // A zero-length burst completes at once without ever raising busy.
            if (bus.amount != '0) begin
              mode_r   <= bus.mode;
              count    <= bus.amount;
              state    <= SHIFT;
              bus.busy <= 1'b1;
            end else begin
              bus.done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          case (mode_r)
            2'b00: begin
              bus.q    <= {bus.q[N-2:0], bus.lin};
              bus.sout <= bus.q[N-1];
            end
            2'b01: begin
`ifdef USHIFT_ARITH_EN
              bus.q    <= {bus.q[N-1], bus.q[N-1:1]};
`else
              bus.q    <= {bus.rin, bus.q[N-1:1]};
`endif
              bus.sout <= bus.q[0];
            end
            2'b10: begin
              bus.q    <= {bus.q[N-2:0], bus.q[N-1]};
              bus.sout <= bus.q[N-1];
            end
            default: begin
              bus.q    <= {bus.q[0], bus.q[N-1:1]};
              bus.sout <= bus.q[0];
            end
          endcase
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
